// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM encoding and constants for the pipeline hazard controller.
package hazard_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT_DRAIN, HALTED} state_t;
  // ID/EX control fields {RF_Wr, Mem_En, Mem_Wr, Flag_Wr, Hlt} as loaded by a bubble
  localparam logic [4:0] NOP_CTRL = 5'b00000;
  localparam int PERF_W_DEF = 16;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator between ID/EX and IF/ID.
module hazard_detect (
  input  logic       mem_rd,
  input  logic       rf_wr,
  input  logic [3:0] dst,
  input  logic [3:0] src1,
  input  logic [3:0] src2,
  input  logic       use1,
  input  logic       use2,
  output logic       lu_stall
);
  assign lu_stall = mem_rd && rf_wr && dst != 4'd0 &&
                    ((use1 && src1 == dst) || (use2 && src2 == dst));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: pipeline register WE/flush/bubble sequencing for stalls, flushes, memory waits and HLT drain.
// Optional PIPELINE_PERF_CTR_EN adds saturating StallCycles/FlushCount outputs.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 64,
  parameter int DRAIN_CYCLES = 3
`ifdef PIPELINE_PERF_CTR_EN
  , parameter int PERF_W = PERF_W_DEF
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       IDEX_MemRd,
  input  logic [3:0] IDEX_RegWrite,
  input  logic       IDEX_RFWr,
  input  logic [3:0] IFID_Src1,
  input  logic [3:0] IFID_Src2,
  input  logic       IFID_Use1,
  input  logic       IFID_Use2,
  input  logic       BranchTaken,
  input  logic       HltID,
  input  logic       MemBusy,
  output logic       PC_WE,
  output logic       IFID_WE,
  output logic       IFID_Flush,
  output logic       IDEX_WE,
  output logic       IDEX_Bubble,
  output logic       EXMEM_WE,
  output logic       MEMWB_WE,
  output logic       Halted,
  output logic       MemTimeout
`ifdef PIPELINE_PERF_CTR_EN
  , output logic [PERF_W-1:0] StallCycles
  , output logic [PERF_W-1:0] FlushCount
`endif
);
  localparam int WW = $clog2(MEM_WAIT_MAX + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  state_t state, saved, eff;
  logic [WW-1:0] wait_cnt;
  logic [DW-1:0] drain_cnt;
  logic lu_stall, go, lu, br, hlt, drain, busy;
  hazard_detect u_detect (
    .mem_rd  (IDEX_MemRd),
    .rf_wr   (IDEX_RFWr),
    .dst     (IDEX_RegWrite),
    .src1    (IFID_Src1),
    .src2    (IFID_Src2),
    .use1    (IFID_Use1),
    .use2    (IFID_Use2),
    .lu_stall(lu_stall)
  );
  // Once memory is ready, MEM_WAIT behaves exactly like the state it interrupted
  always_comb begin
    eff = state == MEM_WAIT ? saved : state;
    go = rst && eff == RUN && !MemBusy;
    lu = go && lu_stall;
    br = go && !lu_stall && BranchTaken;
    hlt = go && !lu_stall && !BranchTaken && HltID;
    drain = rst && eff == HALT_DRAIN && !MemBusy;
    busy = rst && MemBusy && eff != HALTED;
    PC_WE = go && !lu_stall && !hlt;
    IFID_WE = go && !lu_stall;
    IFID_Flush = br || hlt;
    IDEX_WE = go || drain;
    IDEX_Bubble = lu;
    EXMEM_WE = go || drain;
    MEMWB_WE = go || drain;
    Halted = rst && state == HALTED;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      saved <= RUN;
      wait_cnt <= '0;
      drain_cnt <= '0;
      MemTimeout <= 1'b0;
    end else if (busy) begin
      saved <= eff;
      if (wait_cnt == WW'(MEM_WAIT_MAX - 1)) begin
        state <= HALTED;
        MemTimeout <= 1'b1;
      end else begin
        state <= MEM_WAIT;
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      state <= hlt ? HALT_DRAIN : (drain && drain_cnt == DW'(1)) ? HALTED : eff;
      wait_cnt <= '0;
      if (hlt) drain_cnt <= DW'(DRAIN_CYCLES);
      else if (drain) drain_cnt <= drain_cnt - 1'b1;
    end
  end
`ifdef PIPELINE_PERF_CTR_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      StallCycles <= '0;
      FlushCount <= '0;
    end else begin
      if ((busy || lu) && !(&StallCycles)) StallCycles <= StallCycles + 1'b1;
      if (br && !(&FlushCount)) FlushCount <= FlushCount + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed + short random stimulus against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int MAXW = 64;
  localparam int DRN = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic IDEX_MemRd = 1'b0, IDEX_RFWr = 1'b0, IFID_Use1 = 1'b0, IFID_Use2 = 1'b0;
  logic [3:0] IDEX_RegWrite = 4'd0, IFID_Src1 = 4'd0, IFID_Src2 = 4'd0;
  logic BranchTaken = 1'b0, HltID = 1'b0, MemBusy = 1'b0;
  logic PC_WE, IFID_WE, IFID_Flush, IDEX_WE, IDEX_Bubble, EXMEM_WE, MEMWB_WE, Halted, MemTimeout;
`ifdef PIPELINE_PERF_CTR_EN
  logic [15:0] StallCycles, FlushCount;
`endif
  pipeline_hazard_ctrl #(.MEM_WAIT_MAX(MAXW), .DRAIN_CYCLES(DRN)) dut (
    .clk(clk), .rst(rst),
    .IDEX_MemRd(IDEX_MemRd), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_RFWr(IDEX_RFWr),
    .IFID_Src1(IFID_Src1), .IFID_Src2(IFID_Src2), .IFID_Use1(IFID_Use1), .IFID_Use2(IFID_Use2),
    .BranchTaken(BranchTaken), .HltID(HltID), .MemBusy(MemBusy),
    .PC_WE(PC_WE), .IFID_WE(IFID_WE), .IFID_Flush(IFID_Flush), .IDEX_WE(IDEX_WE),
    .IDEX_Bubble(IDEX_Bubble), .EXMEM_WE(EXMEM_WE), .MEMWB_WE(MEMWB_WE),
    .Halted(Halted), .MemTimeout(MemTimeout)
`ifdef PIPELINE_PERF_CTR_EN
    , .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int m_busy = 0, m_drain = 0;
  bit m_halted = 0, m_tmo = 0, m_valid = 0, done = 0;
  function automatic bit m_lu();
    return IDEX_MemRd && IDEX_RFWr && IDEX_RegWrite != 0 &&
           ((IFID_Use1 && IFID_Src1 == IDEX_RegWrite) || (IFID_Use2 && IFID_Src2 == IDEX_RegWrite));
  endfunction
  // {PC_WE, IFID_WE, IFID_Flush, IDEX_WE, IDEX_Bubble, EXMEM_WE, MEMWB_WE}
  function automatic logic [6:0] m_ctrl();
    if (!rst || m_halted || MemBusy) return 7'b0000000;
    if (m_drain > 0) return 7'b0001011;
    if (m_lu()) return 7'b0001111;
    if (BranchTaken) return 7'b1111011;
    if (HltID) return 7'b0111011;
    return 7'b1101011;
  endfunction
  always @(posedge clk) begin
    if (!rst) begin
      m_valid = 1; m_halted = 0; m_tmo = 0; m_drain = 0; m_busy = 0;
    end else if (!m_halted) begin
      if (MemBusy) begin
        m_busy++;
        if (m_busy == MAXW) begin m_halted = 1; m_tmo = 1; end
      end else begin
        m_busy = 0;
        if (m_drain > 0) begin
          m_drain--;
          if (m_drain == 0) m_halted = 1;
        end else if (!m_lu() && !BranchTaken && HltID) m_drain = DRN;
      end
    end
  end
  always @(negedge clk) begin
    if (m_valid && !done) begin
      logic [8:0] act, exp;
      act = {PC_WE, IFID_WE, IFID_Flush, IDEX_WE, IDEX_Bubble, EXMEM_WE, MEMWB_WE, Halted, MemTimeout};
      exp = {m_ctrl(), rst && m_halted, m_tmo};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL cycle_model t=%0t: got %b expected %b (pc,ifwe,flush,idwe,bubble,exwe,mbwe,halted,tmo)", $time, act, exp);
      end
    end
  end
  task automatic lit(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t: got %b expected %b", n, $time, a, e);
    end
  endtask
  task automatic drv(input bit mr, input bit rw, input logic [3:0] d, input logic [3:0] s1, input bit u1,
                     input logic [3:0] s2, input bit u2, input bit b, input bit h, input bit bz);
    @(posedge clk);
    #1;
    IDEX_MemRd = mr; IDEX_RFWr = rw; IDEX_RegWrite = d;
    IFID_Src1 = s1; IFID_Use1 = u1; IFID_Src2 = s2; IFID_Use2 = u2;
    BranchTaken = b; HltID = h; MemBusy = bz;
    #1;
  endtask
  task automatic idle(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic busy(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
  endtask
  initial begin
    idle();
    lit("reset_pc_we", PC_WE, 1'b0);
    lit("reset_memwb_we", MEMWB_WE, 1'b0);
    idle();
    rst = 1'b1;
    #1 lit("run_pc_we", PC_WE, 1'b1);
    lit("run_halted", Halted, 1'b0);
    lit("run_timeout", MemTimeout, 1'b0);
    // LW R3 in ID/EX, ADD R4,R3,R5 in IF/ID
    drv(1, 1, 3, 3, 1, 5, 1, 0, 0, 0);
    lit("lu_pc_we", PC_WE, 1'b0);
    lit("lu_ifid_we", IFID_WE, 1'b0);
    lit("lu_bubble", IDEX_Bubble, 1'b1);
    lit("lu_idex_we", IDEX_WE, 1'b1);
    idle();
    lit("lu_over_pc_we", PC_WE, 1'b1);
    lit("lu_over_bubble", IDEX_Bubble, 1'b0);
    drv(1, 1, 0, 0, 1, 0, 1, 0, 0, 0);
    lit("lu_r0_bubble", IDEX_Bubble, 1'b0);
    drv(1, 1, 7, 7, 0, 2, 1, 0, 0, 0);
    lit("lu_nouse_pc_we", PC_WE, 1'b1);
    drv(1, 1, 9, 1, 1, 9, 1, 0, 0, 0);
    lit("lu_src2_bubble", IDEX_Bubble, 1'b1);
    drv(0, 1, 9, 9, 1, 9, 1, 0, 0, 0);
    lit("alu_dep_no_stall", PC_WE, 1'b1);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    lit("br_flush", IFID_Flush, 1'b1);
    lit("br_pc_we", PC_WE, 1'b1);
    drv(1, 1, 3, 3, 1, 0, 0, 1, 0, 0);
    lit("lu_br_flush", IFID_Flush, 1'b0);
    lit("lu_br_bubble", IDEX_Bubble, 1'b1);
    drv(0, 0, 0, 3, 1, 0, 0, 1, 0, 0);
    lit("br_reeval_flush", IFID_Flush, 1'b1);
    for (int i = 0; i < 5; i++) begin
      busy();
      lit("busy_pc_we", PC_WE, 1'b0);
      lit("busy_memwb_we", MEMWB_WE, 1'b0);
    end
    idle();
    lit("busy_resume_pc_we", PC_WE, 1'b1);
    lit("busy_resume_tmo", MemTimeout, 1'b0);
    busy();
    drv(1, 1, 4, 4, 1, 0, 0, 0, 0, 0);
    lit("busy_exit_lu_bubble", IDEX_Bubble, 1'b1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    lit("hlt_pc_we", PC_WE, 1'b0);
    lit("hlt_flush", IFID_Flush, 1'b1);
    lit("hlt_ifid_we", IFID_WE, 1'b1);
    for (int i = 0; i < DRN; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      lit("drain_halted", Halted, 1'b0);
      lit("drain_ifid_we", IFID_WE, 1'b0);
      lit("drain_br_ignored", IFID_Flush, 1'b0);
    end
    idle();
    lit("halted", Halted, 1'b1);
    lit("halted_memwb_we", MEMWB_WE, 1'b0);
    do_reset();
    #1 lit("rst_after_halt", Halted, 1'b0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    busy();
    busy();
    idle();
    idle();
    lit("drain_busy_not_yet", Halted, 1'b0);
    idle();
    lit("drain_busy_halted", Halted, 1'b1);
    do_reset();
    for (int i = 0; i < MAXW; i++) busy();
    lit("tmo_before", MemTimeout, 1'b0);
    idle();
    lit("tmo_set", MemTimeout, 1'b1);
    lit("tmo_halted", Halted, 1'b1);
    lit("tmo_pc_we", PC_WE, 1'b0);
    do_reset();
    #1 lit("tmo_cleared", MemTimeout, 1'b0);
    lit("tmo_rst_halted", Halted, 1'b0);
    lit("tmo_rst_pc_we", PC_WE, 1'b1);
    for (int i = 0; i < 300; i++) begin
      drv($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
          $urandom_range(0, 1), 4'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0);
      rst = $urandom_range(0, 39) != 0;
    end
    idle();
    rst = 1'b1;
    idle();
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
